// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction-memory read port plus the decoder handshake.
// The fetch unit drives through the master modport; memory and decoder sit on the slave side.
interface fetch_if #(
    parameter int PC_W    = 4,
    parameter int INSTR_W = 8
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               imem_valid;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               instr_ready;
    logic               pc_inc;
    logic               halt;

    modport master (
        output imem_req, imem_addr, instr, instr_valid,
        input  imem_rdata, imem_valid, instr_ready, pc_inc, halt
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_valid,
        output imem_rdata, imem_valid, instr_ready, pc_inc, halt
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, reads one instruction per FETCH and
// presents it to the decoder in ISSUE until accepted.
module fetch_unit #(
    parameter int PC_W    = 4,
    parameter int INSTR_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    fetch_if.master         bus,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            halted
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        ISSUE  = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // NOTE: every variable gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = FETCH;
            end
            FETCH: begin
                if (bus.imem_valid) begin
                    instr_d = bus.imem_rdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // halt wins over pc_inc; both are decoded from the instruction being accepted
                if (bus.instr_ready) begin
                    if (bus.halt) begin
                        state_d = HALTED;
                    end else begin
                        state_d = FETCH;
                        if (bus.pc_inc) pc_d = pc_q + PC_W'(1);
                    end
                end
            end
            HALTED: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.imem_req    = (state_q == FETCH);
        bus.instr_valid = (state_q == ISSUE);
        busy            = (state_q == FETCH) || (state_q == ISSUE);
        halted          = (state_q == HALTED);
    end

    assign bus.imem_addr = pc_q;
    assign bus.instr     = instr_q;
    assign pc            = pc_q;
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the instruction decoder.
- Holds the program counter (PC) and requests 8-bit instructions from instruction memory using a valid handshake.
- Registers each instruction and presents it to the decoder (opcode = instr[7:4], address/operand = instr[3:0]).
- Advances, holds or stops the PC using the decoder's pc_inc and halt outputs.

Parameters:
- PC_W, 4, width of the PC and the instruction-memory address (16-instruction program space).
- INSTR_W, 8, instruction width.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins execution from IDLE, or restarts from HALTED.
- imem_req  output  1  instruction-memory read request.
- imem_addr  output  PC_W  read address; always equals pc.
- imem_rdata  input  INSTR_W  instruction data; sampled only when imem_valid=1 and imem_req=1.
- imem_valid  input  1  memory response strobe; any latency of 0 or more cycles after imem_req rises.
- instr  output  INSTR_W  registered instruction to the decoder.
- instr_valid  output  1  instr holds an instruction not yet consumed.
- instr_ready  input  1  execute side accepts instr this cycle.
- pc_inc  input  1  decoder: advance the PC.
- halt  input  1  decoder: stop execution.
- pc  output  PC_W  current PC.
- busy  output  1  high in FETCH or ISSUE.
- halted  output  1  high in HALTED.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- While rst=1, the following apply immediately, independent of clk:
  - state=IDLE, pc=0, instr=0.
  - imem_req=0, instr_valid=0, busy=0, halted=0.
  - An outstanding memory request is abandoned; a late imem_valid after reset is ignored.
- States:
  - IDLE: all outputs at reset values. start=1 -> FETCH.
  - FETCH: imem_req=1, imem_addr=pc. On imem_valid=1, instr<=imem_rdata and state -> ISSUE. imem_req is low from the next cycle.
  - ISSUE: instr_valid=1; instr is held stable until accepted. On the cycle instr_valid and instr_ready are both 1, the transfer happens, and halt and pc_inc (decoded from the current instr) are sampled that cycle:
    - halt=1 -> HALTED; pc unchanged. halt has priority over pc_inc.
    - halt=0 and pc_inc=1 -> pc<=pc+1 modulo 2^PC_W (15 -> 0 wraps); state -> FETCH.
    - halt=0 and pc_inc=0 -> pc unchanged; state -> FETCH, re-fetching the same address.
  - HALTED: halted=1, instr_valid=0, imem_req=0. start=1 -> pc<=0, halted<=0, state -> FETCH.
- start in FETCH or ISSUE is ignored.
- imem_valid while imem_req=0 is ignored.
- Latency:
  - imem_valid in the first FETCH cycle -> instr_valid=1 on the next cycle.
  - Peak throughput is one instruction per 2 cycles (FETCH, ISSUE).
- instr_valid falls the cycle after acceptance. instr keeps its last value (not cleared) in FETCH and HALTED.
- pc changes only on an accepted ISSUE transfer, a restart from HALTED, or reset.

Test Plan:
1. Reset, start pulse; memory returns 0x30 (ADD), 0x40 (SUB), 0xF0 (HALT) with zero latency; instr_ready=1 -> instr_valid on cycles 2, 4, 6; pc sequence 0, 1, 2; halted=1 with pc=2; no further imem_req.
2. Memory latency of 3 cycles per fetch -> imem_req held with imem_addr stable for 4 cycles; instr_valid one cycle after each imem_valid; pc unchanged while waiting.
3. Backpressure: instr_ready=0 for 5 cycles in ISSUE with instr=0x1A -> instr stays 0x1A, instr_valid stays 1, pc stays constant, imem_req=0; on instr_ready=1, pc increments once.
4. Wrap: preload pc to 15 via a program of 15 NOPs (0x00) followed by NOP -> after accepting the instruction at address 15, pc=0 and the next imem_addr=0.
5. Reset mid-operation: assert rst while imem_req=1 and mid-latency, then drive a late imem_valid -> all outputs at reset values asynchronously; state IDLE; late response ignored; nothing happens until start.
6. Restart: in HALTED, pulse start -> halted=0, pc=0, imem_req=1 on the next cycle; a start pulse during ISSUE has no effect.
